// File: rtl/key_tone_pkg.sv
// -----------------------------------------------------------------------------
// key_tone_pkg
// Shared defaults and constants for the key-to-tone selector.
//   NUM_KEYS_DEF / STACK_DEPTH_DEF / TONE_W_DEF : default parameter values
//   MODE_LAST / MODE_LOW                        : values of the 'mode' input
//   TONE_SILENT                                 : tone code meaning no note
//   idx_w()                                     : width of an index into n items
// -----------------------------------------------------------------------------
package key_tone_pkg;

  localparam int NUM_KEYS_DEF    = 21;
  localparam int STACK_DEPTH_DEF = 8;
  localparam int TONE_W_DEF      = 5;

  localparam logic MODE_LAST = 1'b0;  // most recently pressed held key sounds
  localparam logic MODE_LOW  = 1'b1;  // lowest-index held key sounds

  localparam int TONE_SILENT = 0;

  // Width needed to hold an index 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_tone_selector_note_stack.sv
// -----------------------------------------------------------------------------
// note_stack
// Held-note stack for the key-to-tone selector. Position 0 is the oldest entry,
// position occ-1 the newest. Each cycle it can compact one dead entry (the
// lowest-positioned one) and then push one key on top.
//   clk, rst   : clock, synchronous active-high reset
//   keys_q     : registered key bitmap, decides which entries are live
//   push_vld   : push push_key this cycle
//   push_key   : key index to push
//   top_vld    : a live entry exists
//   top_key    : key index of the topmost live entry
//   stack_cnt  : number of entries with the valid flag set
// -----------------------------------------------------------------------------
module note_stack
  import key_tone_pkg::*;
#(
  parameter int NUM_KEYS    = NUM_KEYS_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int KEY_W       = idx_w(NUM_KEYS_DEF),
  parameter int CNT_W       = $clog2(STACK_DEPTH_DEF + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_q,
  input  logic                push_vld,
  input  logic [KEY_W-1:0]    push_key,
  output logic                top_vld,
  output logic [KEY_W-1:0]    top_key,
  output logic [CNT_W-1:0]    stack_cnt
);

  logic [STACK_DEPTH-1:0][KEY_W-1:0] ent_key;
  logic [STACK_DEPTH-1:0]            ent_vld;
  logic [CNT_W-1:0]                  occ;       // occupied slots, live or dead

  logic [STACK_DEPTH-1:0]            live;
  logic [STACK_DEPTH-1:0]            dead;
  logic                              cmp_vld;
  logic [CNT_W-1:0]                  cmp_pos;

  // Stage 1: after compaction. Stage 2: after invalidation and push.
  logic [STACK_DEPTH-1:0][KEY_W-1:0] key_c, key_n;
  logic [STACK_DEPTH-1:0]            vld_c, vld_i, vld_n;
  logic [CNT_W-1:0]                  occ_c, occ_n;

  // An entry is live only while its key is still held; anything occupied but
  // not live is dead and waits for compaction.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned, which would otherwise infer a latch.
    live = '0;
    dead = '0;
    for (int p = 0; p < STACK_DEPTH; p++) begin
      live[p] = ent_vld[p] & keys_q[ent_key[p]];
      dead[p] = (CNT_W'(p) < occ) & ~live[p];
    end
  end

  // Lowest dead position; scanning downward leaves the lowest one selected.
  always_comb begin
    cmp_vld = 1'b0;
    cmp_pos = '0;
    for (int p = STACK_DEPTH - 1; p >= 0; p--) begin
      if (dead[p]) begin
        cmp_vld = 1'b1;
        cmp_pos = CNT_W'(p);
      end
    end
  end

  // Compaction first: entries above the dead slot slide down one place.
  always_comb begin
    key_c = ent_key;
    vld_c = ent_vld;
    occ_c = occ;
    if (cmp_vld) begin
      for (int p = 0; p < STACK_DEPTH - 1; p++) begin
        if (CNT_W'(p) >= cmp_pos) begin
          key_c[p] = ent_key[p + 1];
          vld_c[p] = ent_vld[p + 1];
        end
      end
      key_c[STACK_DEPTH-1] = '0;
      vld_c[STACK_DEPTH-1] = 1'b0;
      occ_c = occ - CNT_W'(1);
    end
  end

  // Then the push: drop any older copy of the key, evict the oldest entry if
  // compaction did not free a slot, and place the key on top.
  always_comb begin
    vld_i = vld_c;
    key_n = key_c;
    occ_n = occ_c;
    if (push_vld) begin
      for (int p = 0; p < STACK_DEPTH; p++) begin
        if (key_c[p] == push_key) vld_i[p] = 1'b0;
      end
    end
    vld_n = vld_i;
    if (push_vld) begin
      if (occ_c == CNT_W'(STACK_DEPTH)) begin
        for (int p = 0; p < STACK_DEPTH - 1; p++) begin
          key_n[p] = key_c[p + 1];
          vld_n[p] = vld_i[p + 1];
        end
        key_n[STACK_DEPTH-1] = push_key;
        vld_n[STACK_DEPTH-1] = 1'b1;
      end else begin
        for (int p = 0; p < STACK_DEPTH; p++) begin
          if (CNT_W'(p) == occ_c) begin
            key_n[p] = push_key;
            vld_n[p] = 1'b1;
          end
        end
        occ_n = occ_c + CNT_W'(1);
      end
    end
  end

  // Topmost live entry; scanning upward leaves the highest one selected.
  always_comb begin
    top_vld = 1'b0;
    top_key = '0;
    for (int p = 0; p < STACK_DEPTH; p++) begin
      if (live[p]) begin
        top_vld = 1'b1;
        top_key = ent_key[p];
      end
    end
  end

  always_comb begin
    stack_cnt = '0;
    for (int p = 0; p < STACK_DEPTH; p++) begin
      stack_cnt = stack_cnt + CNT_W'(ent_vld[p]);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the entry array is reset because the stack bookkeeping compares
      // keys of every slot; stale contents would leak into invalidation.
      ent_key <= '0;
      ent_vld <= '0;
      occ     <= '0;
    end else begin
      ent_key <= key_n;
      ent_vld <= vld_n;
      occ     <= occ_n;
    end
  end

endmodule

// File: rtl/key_tone_selector.sv
// -----------------------------------------------------------------------------
// key_tone_selector
// Picks the tone to sound from a keyboard bitmap, either the most recently
// pressed held key or the lowest-index held key. All outputs are registered;
// a key change reaches 'tone' two rising edges later.
//   clk        : clock
//   rst        : synchronous active-high reset
//   keys       : held-key bitmap, key i maps to tone i+1
//   mode       : MODE_LAST (0) or MODE_LOW (1)
//   tone       : 0 = silence, k = key k-1 sounding
//   note_on    : one-cycle pulse when tone becomes or changes to a non-zero value
//   note_off   : one-cycle pulse when tone drops to 0
//   stack_cnt  : valid entries in the held-note stack
// -----------------------------------------------------------------------------
module key_tone_selector
  import key_tone_pkg::*;
#(
  parameter int NUM_KEYS    = NUM_KEYS_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int TONE_W      = TONE_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_KEYS-1:0]                keys,
  input  logic                               mode,
  output logic [TONE_W-1:0]                  tone,
  output logic                               note_on,
  output logic                               note_off,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_cnt
);

  localparam int KEY_W = idx_w(NUM_KEYS);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  if ((2 ** TONE_W) < (NUM_KEYS + 1)) begin : g_bad_tone_w
    $error("key_tone_selector: TONE_W too narrow for NUM_KEYS");
  end

  logic [NUM_KEYS-1:0] keys_q;
  logic [NUM_KEYS-1:0] pend;
  logic                mode_q;

  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] cand;
  logic [NUM_KEYS-1:0] push_oh;
  logic [NUM_KEYS-1:0] pend_next;
  logic                push_vld;
  logic [KEY_W-1:0]    push_key;

  logic                top_vld;
  logic [KEY_W-1:0]    top_key;
  logic                low_vld;
  logic [KEY_W-1:0]    low_key;
  logic [TONE_W-1:0]   tone_next;

  // Presses that could not be pushed yet wait in 'pend' until their turn; a
  // release before then simply drops them.
  always_comb begin
    rise      = keys & ~keys_q;
    cand      = (pend | rise) & keys;
    push_oh   = cand & (~cand + NUM_KEYS'(1));  // isolate lowest set bit
    push_vld  = |cand;
    pend_next = cand & ~push_oh;
    push_key  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (push_oh[i]) push_key = KEY_W'(i);
    end
  end

  note_stack #(
    .NUM_KEYS    (NUM_KEYS),
    .STACK_DEPTH (STACK_DEPTH),
    .KEY_W       (KEY_W),
    .CNT_W       (CNT_W)
  ) u_note_stack (
    .clk       (clk),
    .rst       (rst),
    .keys_q    (keys_q),
    .push_vld  (push_vld),
    .push_key  (push_key),
    .top_vld   (top_vld),
    .top_key   (top_key),
    .stack_cnt (stack_cnt)
  );

  // Tone selection works only from registered state, so neither keys nor
  // mode has a combinational path to the outputs.
  always_comb begin
    low_vld = 1'b0;
    low_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_q[i]) begin
        low_vld = 1'b1;
        low_key = KEY_W'(i);
      end
    end

    tone_next = TONE_W'(TONE_SILENT);
    if (mode_q == MODE_LOW) begin
      if (low_vld) tone_next = TONE_W'(int'(low_key) + 1);
    end else begin
      if (top_vld) tone_next = TONE_W'(int'(top_key) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q   <= '0;
      pend     <= '0;
      mode_q   <= MODE_LAST;
      tone     <= TONE_W'(TONE_SILENT);
      note_on  <= 1'b0;
      note_off <= 1'b0;
    end else begin
      keys_q   <= keys;
      pend     <= pend_next;
      mode_q   <= mode;
      tone     <= tone_next;
      note_on  <= (tone_next != TONE_W'(TONE_SILENT)) && (tone_next != tone);
      note_off <= (tone_next == TONE_W'(TONE_SILENT)) && (tone != TONE_W'(TONE_SILENT));
    end
  end

endmodule

// File: tb/tb_key_tone_selector.sv
// -----------------------------------------------------------------------------
// tb_key_tone_selector
// Self-checking bench for key_tone_selector: directed scenarios with fixed
// expectations plus randomized key/mode/reset activity, all outputs compared
// every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_key_tone_selector;

  localparam int NK    = 21;
  localparam int DEPTH = 8;
  localparam int TW    = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] keys;
  logic          mode;
  logic [TW-1:0] tone;
  logic          note_on;
  logic          note_off;
  logic [CW-1:0] stack_cnt;

  int  n_cmp  = 0;
  int  n_bad  = 0;
  bit  chk_en = 1'b0;

  key_tone_selector #(
    .NUM_KEYS    (NK),
    .STACK_DEPTH (DEPTH),
    .TONE_W      (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys      (keys),
    .mode      (mode),
    .tone      (tone),
    .note_on   (note_on),
    .note_off  (note_off),
    .stack_cnt (stack_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The held-note stack is a queue, oldest at the front. Each edge: pick the
  // tone from the pre-edge state, delete the first dead entry, then push the
  // lowest waiting press (dropping older copies and the oldest on overflow).
  typedef struct {
    int key;
    bit vld;
  } ent_t;

  ent_t    m_stk[$];
  bit [NK-1:0] m_keys_q = '0;
  bit [NK-1:0] m_pend   = '0;
  bit      m_mode_q = 1'b0;
  int      m_tone   = 0;
  bit      m_on     = 1'b0;
  bit      m_off    = 1'b0;

  function automatic int lowest_set(input bit [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int model_cnt();
    int n = 0;
    foreach (m_stk[i]) if (m_stk[i].vld) n++;
    return n;
  endfunction

  task automatic model_step();
    int          tn;
    int          d;
    int          k;
    bit [NK-1:0] rise;
    bit [NK-1:0] cand;
    if (rst) begin
      m_stk.delete();
      m_keys_q = '0;
      m_pend   = '0;
      m_mode_q = 1'b0;
      m_tone   = 0;
      m_on     = 1'b0;
      m_off    = 1'b0;
      return;
    end
    tn = 0;
    if (m_mode_q) begin
      k = lowest_set(m_keys_q);
      if (k >= 0) tn = k + 1;
    end else begin
      for (int i = m_stk.size() - 1; i >= 0; i--) begin
        if (m_stk[i].vld && m_keys_q[m_stk[i].key]) begin
          tn = m_stk[i].key + 1;
          break;
        end
      end
    end
    d = -1;
    for (int i = 0; i < m_stk.size(); i++) begin
      if (!(m_stk[i].vld && m_keys_q[m_stk[i].key])) begin
        d = i;
        break;
      end
    end
    if (d >= 0) m_stk.delete(d);
    rise = keys & ~m_keys_q;
    cand = (m_pend | rise) & keys;
    k = lowest_set(cand);
    if (k >= 0) begin
      foreach (m_stk[i]) if (m_stk[i].key == k) m_stk[i].vld = 1'b0;
      if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
      m_stk.push_back('{key: k, vld: 1'b1});
      cand[k] = 1'b0;
    end
    m_pend   = cand;
    m_on     = (tn != 0) && (tn != m_tone);
    m_off    = (tn == 0) && (m_tone != 0);
    m_tone   = tn;
    m_keys_q = keys;
    m_mode_q = mode;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("tone",      32'(tone),      32'(m_tone));
      check("note_on",   32'(note_on),   32'(m_on));
      check("note_off",  32'(note_off),  32'(m_off));
      check("stack_cnt", 32'(stack_cnt), 32'(model_cnt()));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    keys = '0;
    mode = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_tone",  32'(tone),      0);
    check("rst_on",    32'(note_on),   0);
    check("rst_off",   32'(note_off),  0);
    check("rst_cnt",   32'(stack_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_n(2);

    // Two overlapping notes in last-pressed mode.
    keys[4] = 1'b1;
    wait_n(2);
    check("a_tone5", 32'(tone), 5);
    check("a_on5",   32'(note_on), 1);
    wait_n(1);
    keys[9] = 1'b1;
    wait_n(2);
    check("a_tone10", 32'(tone), 10);
    check("a_on10",   32'(note_on), 1);
    wait_n(3);
    keys[9] = 1'b0;
    wait_n(2);
    check("a_back5", 32'(tone), 5);
    check("a_on_b5", 32'(note_on), 1);
    wait_n(3);
    keys[4] = 1'b0;
    wait_n(2);
    check("a_silent", 32'(tone), 0);
    check("a_off",    32'(note_off), 1);
    wait_n(4);

    // Three simultaneous presses are pushed lowest first, one per cycle.
    keys[2]  = 1'b1;
    keys[7]  = 1'b1;
    keys[12] = 1'b1;
    wait_n(2);
    check("b_tone3", 32'(tone), 3);
    wait_n(1);
    check("b_tone8", 32'(tone), 8);
    wait_n(1);
    check("b_tone13", 32'(tone), 13);
    check("b_cnt3",   32'(stack_cnt), 3);
    keys = '0;
    wait_n(6);

    // Overflow: ten presses into an eight-deep stack lose keys 0 and 1.
    for (int k = 0; k < 10; k++) begin
      keys[k] = 1'b1;
      wait_n(2);
    end
    wait_n(2);
    check("c_cnt_full", 32'(stack_cnt), DEPTH);
    check("c_tone10",   32'(tone), 10);
    for (int k = 9; k >= 2; k--) begin
      keys[k] = 1'b0;
      wait_n(2);
      check($sformatf("c_walk%0d", k), 32'(tone), (k == 2) ? 0 : k);
    end
    keys = '0;
    wait_n(10);

    // Lowest-index mode, then back to last-pressed.
    mode = 1'b1;
    wait_n(1);
    keys[5] = 1'b1;
    keys[3] = 1'b1;
    wait_n(4);
    check("d_low4", 32'(tone), 4);
    mode = 1'b0;
    wait_n(2);
    check("d_last6", 32'(tone), 6);
    check("d_on6",   32'(note_on), 1);

    // Quick release/re-press keeps exactly one entry for the key.
    keys[6] = 1'b1;
    wait_n(4);
    check("e_tone7", 32'(tone), 7);
    check("e_cnt3",  32'(stack_cnt), 3);
    keys[6] = 1'b0;
    wait_n(1);
    keys[6] = 1'b1;
    wait_n(4);
    check("e_tone7b", 32'(tone), 7);
    check("e_cnt3b",  32'(stack_cnt), 3);

    // Reset mid-note: silence without note_off, held key replays afterwards.
    keys = '0;
    wait_n(6);
    keys[9] = 1'b1;
    wait_n(4);
    check("f_tone10", 32'(tone), 10);
    rst = 1'b1;
    wait_n(1);
    check("f_rst_tone", 32'(tone), 0);
    check("f_rst_off",  32'(note_off), 0);
    check("f_rst_on",   32'(note_on), 0);
    wait_n(1);
    rst = 1'b0;
    wait_n(1);
    check("f_edge1_tone", 32'(tone), 0);
    check("f_edge1_on",   32'(note_on), 0);
    wait_n(1);
    check("f_edge2_tone", 32'(tone), 10);
    check("f_edge2_on",   32'(note_on), 1);

    // Randomized activity, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      int idx;
      @(negedge clk);
      rst = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        idx = $urandom_range(0, NK - 1);
        keys[idx] = ~keys[idx];
      end
      if (r < 10) begin
        idx = $urandom_range(0, NK - 1);
        keys[idx] = ~keys[idx];
      end
      if (r == 50) keys = keys | NK'($urandom());
      if (r == 51) keys = '0;
      if ($urandom_range(0, 149) == 0) mode = ~mode;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst  = 1'b0;
    keys = '0;
    wait_n(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
